// File: rtl/leaky_relu_h_cache_pkg.sv
// Shared types and constants for the leaky-ReLU H cache.
// H values are signed Q8.8 pre-activations saved on the forward pass and replayed on the backward pass.
package leaky_relu_h_cache_pkg;

  localparam int H_W         = 16;
  localparam int H_DEPTH_DEF = 16;
  localparam int NUM_COLS    = 2;

  typedef logic signed [H_W-1:0] h_t;

  typedef struct packed {
    logic valid;
    h_t   data;
  } h_wr_req_t;

  function automatic bit depth_ok(input int d);
    return (d >= 2) && (d <= 64) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/leaky_relu_h_cache_col.sv
// One column of the H cache: a first-word-fall-through FIFO with its own
// pointers and count, plus single-cycle overflow/underflow pulses.
module leaky_relu_h_cache_col
  import leaky_relu_h_cache_pkg::*;
#(
  parameter int H_DEPTH = H_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  h_wr_req_t                  wr_req,
  input  logic                       rd_valid,
  output h_t                         rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(H_DEPTH):0]   count,
  output logic                       ovf_pulse,
  output logic                       unf_pulse
);

  localparam int AW = $clog2(H_DEPTH);
  localparam int CW = AW + 1;

  h_t            mem [H_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_en, rd_en;

  assign empty = (count == '0);
  assign full  = (count == CW'(H_DEPTH));

  // A full column still accepts a write when the same edge pops the head.
  assign wr_en     = wr_req.valid && (!full || rd_valid) && !clear && !rst;
  assign rd_en     = rd_valid && !empty && !clear && !rst;
  assign ovf_pulse = wr_req.valid && full && !rd_valid && !clear;
  assign unf_pulse = rd_valid && empty && !clear;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_req.data;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head is visible in the same cycle as the gradient valid; no bypass of a same-cycle write.
  always_comb begin
    rd_data = '0;
    if (!empty) rd_data = mem[rd_ptr];
  end

endmodule

// File: rtl/leaky_relu_h_cache.sv
// Two independent H columns for the leaky-ReLU derivative unit, with shared
// sticky overflow/underflow flags.
module leaky_relu_h_cache
  import leaky_relu_h_cache_pkg::*;
#(
  parameter int H_DEPTH = H_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      lr_h_clear_in,
  input  logic                      lr_h_wr_valid_1_in,
  input  logic                      lr_h_wr_valid_2_in,
  input  logic signed [15:0]        lr_h_wr_data_1_in,
  input  logic signed [15:0]        lr_h_wr_data_2_in,
  input  logic                      lr_h_rd_valid_1_in,
  input  logic                      lr_h_rd_valid_2_in,
  output logic signed [15:0]        lr_h_data_1_out,
  output logic signed [15:0]        lr_h_data_2_out,
  output logic                      lr_h_empty_1_out,
  output logic                      lr_h_empty_2_out,
  output logic                      lr_h_full_1_out,
  output logic                      lr_h_full_2_out,
  output logic [$clog2(H_DEPTH):0]  lr_h_count_1_out,
  output logic [$clog2(H_DEPTH):0]  lr_h_count_2_out,
  output logic                      lr_h_overflow_out,
  output logic                      lr_h_underflow_out
);

  localparam int CW = $clog2(H_DEPTH) + 1;

  if (!depth_ok(H_DEPTH)) begin : g_bad_depth
    $error("H_DEPTH must be a power of two in 2..64");
  end

  h_wr_req_t [NUM_COLS-1:0]         wr_req;
  logic      [NUM_COLS-1:0]         rd_valid, empty, full, ovf_p, unf_p;
  h_t        [NUM_COLS-1:0]         rd_data;
  logic      [NUM_COLS-1:0][CW-1:0] count;
  logic                             ovf_q, unf_q;

  assign wr_req[0] = '{valid: lr_h_wr_valid_1_in, data: lr_h_wr_data_1_in};
  assign wr_req[1] = '{valid: lr_h_wr_valid_2_in, data: lr_h_wr_data_2_in};
  assign rd_valid  = {lr_h_rd_valid_2_in, lr_h_rd_valid_1_in};

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    leaky_relu_h_cache_col #(.H_DEPTH(H_DEPTH)) u_col (
      .clk       (clk),
      .rst       (rst),
      .clear     (lr_h_clear_in),
      .wr_req    (wr_req[c]),
      .rd_valid  (rd_valid[c]),
      .rd_data   (rd_data[c]),
      .empty     (empty[c]),
      .full      (full[c]),
      .count     (count[c]),
      .ovf_pulse (ovf_p[c]),
      .unf_pulse (unf_p[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || lr_h_clear_in) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (|ovf_p);
      unf_q <= unf_q | (|unf_p);
    end
  end

  assign lr_h_data_1_out    = rd_data[0];
  assign lr_h_data_2_out    = rd_data[1];
  assign lr_h_empty_1_out   = empty[0];
  assign lr_h_empty_2_out   = empty[1];
  assign lr_h_full_1_out    = full[0];
  assign lr_h_full_2_out    = full[1];
  assign lr_h_count_1_out   = count[0];
  assign lr_h_count_2_out   = count[1];
  assign lr_h_overflow_out  = ovf_q;
  assign lr_h_underflow_out = unf_q;

endmodule

// File: tb/tb_leaky_relu_h_cache.sv
// Scoreboard bench for leaky_relu_h_cache: the driver queues expected H per
// column, a negedge monitor compares head/count/flags and retires popped entries.
module tb_leaky_relu_h_cache;
  import leaky_relu_h_cache_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0, clr = 1'b0;
  logic [1:0] w = '0, r = '0;
  h_t         d [2];
  h_t         dout [2];
  logic [1:0] empty, full;
  logic [4:0] cnt [2];
  logic       ovf, unf;

  h_t   q [2][$];
  bit   [1:0] popped = '0;
  bit   exp_ovf = 1'b0, exp_unf = 1'b0;
  bit   mon_en = 1'b0;
  int   checks = 0, errors = 0;

  always #5 clk = ~clk;

  leaky_relu_h_cache #(.H_DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .lr_h_clear_in      (clr),
    .lr_h_wr_valid_1_in (w[0]),
    .lr_h_wr_valid_2_in (w[1]),
    .lr_h_wr_data_1_in  (d[0]),
    .lr_h_wr_data_2_in  (d[1]),
    .lr_h_rd_valid_1_in (r[0]),
    .lr_h_rd_valid_2_in (r[1]),
    .lr_h_data_1_out    (dout[0]),
    .lr_h_data_2_out    (dout[1]),
    .lr_h_empty_1_out   (empty[0]),
    .lr_h_empty_2_out   (empty[1]),
    .lr_h_full_1_out    (full[0]),
    .lr_h_full_2_out    (full[1]),
    .lr_h_count_1_out   (cnt[0]),
    .lr_h_count_2_out   (cnt[1]),
    .lr_h_overflow_out  (ovf),
    .lr_h_underflow_out (unf)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: status against the model, head against the scoreboard, retire on pop.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("count_%0d", c + 1), int'(cnt[c]), q[c].size());
        chk($sformatf("empty_%0d", c + 1), int'(empty[c]), int'(q[c].size() == 0));
        chk($sformatf("full_%0d", c + 1), int'(full[c]), int'(q[c].size() == DEPTH));
        chk($sformatf("data_%0d", c + 1), int'(dout[c]),
            (q[c].size() != 0) ? int'(q[c][0]) : 0);
        if (r[c] && !clr && !rst && q[c].size() != 0) begin
          void'(q[c].pop_front());
          popped[c] = 1'b1;
        end
      end
      chk("overflow", int'(ovf), int'(exp_ovf));
      chk("underflow", int'(unf), int'(exp_unf));
    end
  end

  // Drive one cycle of stimulus; queue the expected response at the edge.
  task automatic step(input logic w1 = 0, input h_t d1 = '0, input logic r1 = 0,
                      input logic w2 = 0, input h_t d2 = '0, input logic r2 = 0,
                      input logic c = 0, input logic rs = 0);
    w = {w2, w1}; d[0] = d1; d[1] = d2; r = {r2, r1}; clr = c; rst = rs;
    @(posedge clk);
    if (rs || c) begin
      q[0].delete(); q[1].delete();
      exp_ovf = 1'b0; exp_unf = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        int  sz;
        bit  rd_ok;
        sz    = q[k].size() + int'(popped[k]);
        rd_ok = r[k] && (sz > 0);
        if (r[k] && sz == 0) exp_unf = 1'b1;
        if (w[k]) begin
          if (sz < DEPTH || rd_ok) q[k].push_back(d[k]);
          else exp_ovf = 1'b1;
        end
      end
    end
    popped = '0;
    #1;
    w = '0; r = '0; clr = 1'b0; rst = 1'b0;
  endtask

  initial begin
    d[0] = '0; d[1] = '0;
    step(.rs(1)); step(.rs(1));
    mon_en = 1'b1;
    chk("rst_empty_1", int'(empty[0]), 1);
    chk("rst_full_2", int'(full[1]), 0);

    // Three writes then three pops; first write right after reset.
    step(.w1(1), .d1(16'sh0180));
    step(.w1(1), .d1(16'shFF00));
    step(.w1(1), .d1(16'sh0040));
    chk("fwft_head_1", int'(dout[0]), int'(16'sh0180));
    chk("cnt3_1", int'(cnt[0]), 3);
    step(.r1(1)); step(.r1(1)); step(.r1(1));
    chk("drained_empty_1", int'(empty[0]), 1);
    chk("drained_data_1", int'(dout[0]), 0);

    // Overflow column 2; column 1 untouched.
    for (int i = 0; i < 17; i++) begin
      step(.w2(1), .d2(h_t'(16'h0200 + i)));
      if (i == 15) chk("full_after_16", int'(full[1]), 1);
    end
    chk("ovf_set", int'(ovf), 1);
    chk("cnt_full_2", int'(cnt[1]), 16);
    chk("cnt_idle_1", int'(cnt[0]), 0);
    chk("head_kept_2", int'(dout[1]), int'(16'sh0200));
    step(.c(1), .w1(1), .d1(16'sh7777));
    chk("clr_ovf", int'(ovf), 0);
    chk("clr_cnt_1", int'(cnt[0]), 0);

    // Full column with concurrent write/read across pointer wrap.
    for (int i = 0; i < 16; i++) step(.w1(1), .d1(h_t'(16'h1000 + i)));
    for (int i = 0; i < 20; i++) step(.w1(1), .d1(h_t'(16'h2000 + i)), .r1(1));
    chk("wrap_cnt_1", int'(cnt[0]), 16);
    chk("wrap_no_ovf", int'(ovf), 0);
    chk("wrap_no_unf", int'(unf), 0);
    chk("wrap_head_1", int'(dout[0]), int'(16'sh2004));
    for (int i = 0; i < 16; i++) step(.r1(1));

    // Read+write on empty column 2: write kept, underflow flagged, no bypass.
    step(.w2(1), .d2(16'sh0100), .r2(1));
    chk("unf_set", int'(unf), 1);
    chk("unf_cnt_2", int'(cnt[1]), 1);
    chk("unf_data_2", int'(dout[1]), int'(16'sh0100));
    step(.r2(1));

    // Clear, then reset, each with every strobe active.
    for (int i = 0; i < 5; i++) step(.w1(1), .d1(h_t'(16'h0300 + i)));
    step(.c(1), .w1(1), .d1(16'sh1111), .r1(1), .w2(1), .d2(16'sh2222), .r2(1));
    chk("clr5_cnt_1", int'(cnt[0]), 0);
    chk("clr5_unf", int'(unf), 0);
    chk("clr5_empty_2", int'(empty[1]), 1);
    for (int i = 0; i < 5; i++) step(.w1(1), .d1(h_t'(16'h0400 + i)));
    step(.r2(1));
    chk("pre_rst_unf", int'(unf), 1);
    step(.rs(1), .c(1), .w1(1), .d1(16'sh3333), .r1(1), .w2(1), .d2(16'sh4444), .r2(1));
    chk("rst_cnt_1", int'(cnt[0]), 0);
    chk("rst_cnt_2", int'(cnt[1]), 0);
    chk("rst_unf", int'(unf), 0);
    chk("rst_data_1", int'(dout[0]), 0);
    step(.w2(1), .d2(16'sh0055));
    step(.r2(1));
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
